// File: rtl/cpu_mem_pkg.sv
// Shared defaults and FSM encoding for the CPU memory responder.
package cpu_mem_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDRSIZE   = 12;
    localparam int DEF_DUMP_WORDS = 10;
    localparam int DEF_HALT_CODE  = 5;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_DUMP_RD  = 2'd1;
    localparam logic [1:0] ST_DUMP_VLD = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        DUMP_RD  = ST_DUMP_RD,
        DUMP_VLD = ST_DUMP_VLD,
        DONE     = ST_DONE
    } state_t;

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous RAM with a registered, write-through read port.
module mem_bank #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] addr,
    input  logic [WIDTH-1:0]    wdata,
    output logic [WIDTH-1:0]    rdata
);

    logic [WIDTH-1:0] mem [2**ADDRSIZE];

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[addr] <= wdata;
        end
    end

    // rdata holds while en is low, which lets the owner freeze the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en) begin
            rdata <= we ? wdata : mem[addr];
        end
    end

endmodule

// File: rtl/cpu_mem_responder.sv
// Serves CPU instruction/data ports from on-chip RAM, supports preload,
// and streams the first DUMP_WORDS data words out after the halt code.
module cpu_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDRSIZE   = DEF_ADDRSIZE,
    parameter int DUMP_WORDS = DEF_DUMP_WORDS,
    parameter int HALT_CODE  = DEF_HALT_CODE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    input  logic [ADDRSIZE-1:0] MEM_ADDR,
    input  logic [0:WIDTH-1]    MEM_OUT,
    input  logic                MEM_CTRL,
    output logic [0:WIDTH-1]    MEM_IN,
    input  logic [6:0]          debuger,
    input  logic                ld_we,
    input  logic                ld_imem,
    input  logic [ADDRSIZE-1:0] ld_addr,
    input  logic [WIDTH-1:0]    ld_data,
    output logic                dump_valid,
    input  logic                dump_ready,
    output logic [ADDRSIZE-1:0] dump_addr,
    output logic [WIDTH-1:0]    dump_data,
    output logic                dump_done
);

    state_t               state, state_next;
    logic [ADDRSIZE-1:0]  dump_cnt;
    logic [WIDTH-1:0]     mem_in_hold;
    logic                 idle, last_word, handshake, cpu_view;
    logic                 imem_we, dmem_en, dmem_we, dmem_preload, cpu_write;
    logic [ADDRSIZE-1:0]  imem_addr, dmem_addr;
    logic [WIDTH-1:0]     dmem_wdata, imem_rdata, dmem_rdata;

    assign idle      = (state == IDLE);
    assign last_word = (dump_cnt == ADDRSIZE'(DUMP_WORDS - 1));
    assign handshake = dump_valid && dump_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (debuger == 7'(HALT_CODE)) state_next = DUMP_RD;
            DUMP_RD:  state_next = DUMP_VLD;
            DUMP_VLD: if (dump_ready) state_next = last_word ? DONE : DUMP_RD;
            DONE:     state_next = DONE;
            default:  state_next = IDLE;
        endcase
    end

    // Preload owns the data port over a concurrent CPU write.
    always_comb begin
        dmem_preload = idle && ld_we && !ld_imem;
        cpu_write    = idle && MEM_CTRL && !dmem_preload;
        dmem_en      = idle || (state == DUMP_RD);
        dmem_we      = dmem_preload || cpu_write;
        dmem_addr    = dmem_preload ? ld_addr : (idle ? MEM_ADDR : dump_cnt);
        dmem_wdata   = dmem_preload ? ld_data : WIDTH'(MEM_OUT);
        imem_we      = idle && ld_we && ld_imem;
        imem_addr    = imem_we ? ld_addr : INS_ADDR;
    end

    mem_bank #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_imem (
        .clk   (clk),
        .rst   (rst),
        .en    (idle),
        .we    (imem_we),
        .addr  (imem_addr),
        .wdata (ld_data),
        .rdata (imem_rdata)
    );

    mem_bank #(.WIDTH(WIDTH), .ADDRSIZE(ADDRSIZE)) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .en    (dmem_en),
        .we    (dmem_we),
        .addr  (dmem_addr),
        .wdata (dmem_wdata),
        .rdata (dmem_rdata)
    );

    // The first dump read overwrites the shared read register, so the CPU
    // word is captured on that edge and replayed for the rest of the dump.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dump_cnt    <= '0;
            dump_addr   <= '0;
            mem_in_hold <= '0;
        end else begin
            if (idle) begin
                dump_cnt <= '0;
            end else if (handshake && !last_word) begin
                dump_cnt <= dump_cnt + 1'b1;
            end
            if (state == DUMP_RD) begin
                dump_addr <= dump_cnt;
            end
            if (state == DUMP_RD && dump_cnt == '0) begin
                mem_in_hold <= dmem_rdata;
            end
        end
    end

    always_comb begin
        cpu_view   = idle || (state == DUMP_RD && dump_cnt == '0);
        INS_MEM    = imem_rdata;
        MEM_IN     = cpu_view ? dmem_rdata : mem_in_hold;
        dump_data  = cpu_view ? '0 : dmem_rdata;
        dump_valid = (state == DUMP_VLD);
        dump_done  = (state == DONE);
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Self-checking bench for cpu_mem_responder: directed steps plus random
// CPU/preload traffic checked against array-based memory models.
module tb_cpu_mem_responder;

    localparam int W  = 32;
    localparam int AW = 12;
    localparam int NW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] INS_ADDR, MEM_ADDR, ld_addr;
    logic [W-1:0]  INS_MEM, MEM_IN, MEM_OUT, ld_data, dump_data;
    logic          MEM_CTRL, ld_we, ld_imem, dump_valid, dump_ready, dump_done;
    logic [6:0]    debuger;
    logic [AW-1:0] dump_addr;

    logic [W-1:0]  imem_m [2**AW];
    logic [W-1:0]  dmem_m [2**AW];
    int            errors = 0;
    int            checks = 0;

    cpu_mem_responder #(.WIDTH(W), .ADDRSIZE(AW), .DUMP_WORDS(NW), .HALT_CODE(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .INS_ADDR   (INS_ADDR),
        .INS_MEM    (INS_MEM),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_OUT    (MEM_OUT),
        .MEM_CTRL   (MEM_CTRL),
        .MEM_IN     (MEM_IN),
        .debuger    (debuger),
        .ld_we      (ld_we),
        .ld_imem    (ld_imem),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic clearInputs();
        INS_ADDR = '0; MEM_ADDR = '0; MEM_OUT = '0; MEM_CTRL = 1'b0;
        ld_we = 1'b0; ld_imem = 1'b0; ld_addr = '0; ld_data = '0;
        debuger = 7'd0; dump_ready = 1'b0;
    endtask

    task automatic nonHaltCode();
        debuger = 7'($urandom_range(0, 127));
        if (debuger == 7'd5) debuger = 7'd6;
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_ins_mem"}, INS_MEM, 32'h0);
        checkOutput({pfx, "_mem_in"}, MEM_IN, 32'h0);
        checkOutput({pfx, "_dump_valid"}, 32'(dump_valid), 32'h0);
        checkOutput({pfx, "_dump_addr"}, 32'(dump_addr), 32'h0);
        checkOutput({pfx, "_dump_data"}, dump_data, 32'h0);
        checkOutput({pfx, "_dump_done"}, 32'(dump_done), 32'h0);
    endtask

    task automatic doReset(input string pfx);
        rst = 1'b1;
        #2;
        checkResetValues(pfx);
        clearInputs();
        applyStimulus();
        rst = 1'b0;
        applyStimulus();
    endtask

    task automatic preload(input logic isImem, input logic [AW-1:0] a, input logic [W-1:0] d);
        clearInputs();
        ld_we = 1'b1; ld_imem = isImem; ld_addr = a; ld_data = d;
        if (isImem) imem_m[a] = d; else dmem_m[a] = d;
        applyStimulus();
        ld_we = 1'b0;
    endtask

    task automatic doHalt();
        clearInputs();
        debuger = 7'd5; MEM_ADDR = 12'd3; INS_ADDR = 12'd2;
        applyStimulus();
        nonHaltCode();
    endtask

    // Drives the sink after a halt edge; counts edges since that halt edge.
    task automatic doDump(input int stallWord, input int stallLen, input int abortAfter, input int expDoneEdge);
        int e = 0;
        int nXfer = 0;
        int stallCnt = 0;
        int doneEdge = -1;
        bit stop = 0;
        MEM_CTRL = 1'b1; MEM_ADDR = 12'd0; MEM_OUT = 32'hDEADBEEF;
        ld_we = 1'b1; ld_imem = 1'b0; ld_addr = 12'd1; ld_data = 32'hBAD0BAD0;
        while (e < 100 && !stop) begin
            INS_ADDR = AW'($urandom_range(0, 31));
            if (dump_done) begin
                doneEdge = e;
                stop = 1;
            end else if (dump_valid && int'(dump_addr) == stallWord && stallCnt < stallLen) begin
                dump_ready = 1'b0;
                checkOutput("stall_valid", 32'(dump_valid), 32'h1);
                checkOutput("stall_addr", 32'(dump_addr), 32'(stallWord));
                checkOutput("stall_data", dump_data, 32'(100 + stallWord));
                stallCnt++;
                applyStimulus(); e++;
            end else if (dump_valid) begin
                dump_ready = 1'b1;
                checkOutput("xfer_addr", 32'(dump_addr), 32'(nXfer));
                checkOutput("xfer_data", dump_data, 32'(100 + nXfer));
                nXfer++;
                applyStimulus(); e++;
                if (abortAfter != 0 && nXfer == abortAfter) stop = 1;
            end else begin
                dump_ready = 1'($urandom_range(0, 1));
                applyStimulus(); e++;
            end
        end
        if (abortAfter != 0) begin
            checkOutput("abort_xfer_count", 32'(nXfer), 32'(abortAfter));
        end else begin
            checkOutput("xfer_count", 32'(nXfer), 32'(NW));
            checkOutput("done_edge", 32'(doneEdge), 32'(expDoneEdge));
            checkOutput("done_valid_low", 32'(dump_valid), 32'h0);
            checkOutput("dump_mem_in_hold", MEM_IN, dmem_m[3]);
            checkOutput("dump_ins_mem_hold", INS_MEM, imem_m[2]);
        end
    endtask

    initial begin
        int op;
        logic [W-1:0] expIns, expMem;
        clearInputs();
        #3;
        doReset("rst0");

        // Instruction fetch latency
        for (int i = 0; i < 4; i++) preload(1'b1, AW'(i), 32'hA0000001 + 32'(i));
        clearInputs();
        for (int i = 0; i < 4; i++) begin
            INS_ADDR = AW'(i);
            applyStimulus();
            checkOutput($sformatf("ifetch%0d", i), INS_MEM, 32'hA0000001 + 32'(i));
        end

        // CPU write is visible on the same edge and readable afterwards
        MEM_CTRL = 1'b1; MEM_ADDR = 12'd7; MEM_OUT = 32'h12345678;
        applyStimulus();
        checkOutput("wr_through", MEM_IN, 32'h12345678);
        MEM_CTRL = 1'b0; MEM_ADDR = 12'd0;
        applyStimulus();
        MEM_ADDR = 12'd7;
        applyStimulus();
        checkOutput("wr_readback", MEM_IN, 32'h12345678);

        // Preload beats a same-cycle CPU write
        ld_we = 1'b1; ld_imem = 1'b0; ld_addr = 12'd3; ld_data = 32'h11;
        MEM_CTRL = 1'b1; MEM_ADDR = 12'd3; MEM_OUT = 32'h22;
        applyStimulus();
        clearInputs();
        MEM_ADDR = 12'd3;
        applyStimulus();
        checkOutput("preload_wins", MEM_IN, 32'h11);

        // Random CPU and preload traffic over addresses 16..31
        for (int i = 16; i < 32; i++) begin
            preload(1'b1, AW'(i), $urandom);
            preload(1'b0, AW'(i), $urandom);
        end
        for (int n = 0; n < 80; n++) begin
            clearInputs();
            nonHaltCode();
            op = $urandom_range(0, 4);
            INS_ADDR = AW'(16 + $urandom_range(0, 15));
            MEM_ADDR = AW'(16 + $urandom_range(0, 15));
            MEM_OUT  = $urandom;
            ld_addr  = AW'(16 + $urandom_range(0, 15));
            ld_data  = $urandom;
            MEM_CTRL = (op == 1 || op == 4);
            ld_we    = (op >= 2);
            ld_imem  = (op == 3);
            expIns = imem_m[INS_ADDR];
            expMem = (op == 1) ? MEM_OUT : dmem_m[MEM_ADDR];
            if (op == 1) dmem_m[MEM_ADDR] = MEM_OUT;
            if (op == 2 || op == 4) dmem_m[ld_addr] = ld_data;
            if (op == 3) imem_m[ld_addr] = ld_data;
            applyStimulus();
            if (op != 3) checkOutput($sformatf("rnd%0d_ins", n), INS_MEM, expIns);
            if (op == 0 || op == 1) checkOutput($sformatf("rnd%0d_mem", n), MEM_IN, expMem);
        end

        // Full dump with an always-ready sink
        for (int i = 0; i < NW; i++) preload(1'b0, AW'(i), 32'(100 + i));
        doHalt();
        doDump(-1, 0, 0, 2 * NW);
        checkOutput("done_level", 32'(dump_done), 32'h1);
        clearInputs();
        doReset("rst1");
        MEM_ADDR = 12'd0;
        applyStimulus();
        MEM_ADDR = 12'd1;
        checkOutput("dmem0_kept", MEM_IN, 32'd100);
        applyStimulus();
        checkOutput("dmem1_kept", MEM_IN, 32'd101);

        // Sink stalls for five cycles on word 4
        doHalt();
        doDump(4, 5, 0, 2 * NW + 5);
        clearInputs();
        doReset("rst2");

        // Reset mid-dump, then a fresh dump from word 0
        doHalt();
        doDump(-1, 0, 3, 0);
        doReset("rst_mid");
        doHalt();
        doDump(-1, 0, 0, 2 * NW);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Synthesizable memory-side responder for the CPU's instruction and data ports: it serves instruction fetches and data reads/writes from on-chip RAM. It detects the CPU halt code and streams the first data words out over a valid/ready dump port. It also provides a preload port for filling both memories before the CPU runs. It replaces behavioural memory models around the CPU in both simulation and synthesis.

## Interface
- WIDTH, 32, data word width
- ADDRSIZE, 12, address width; each memory holds 2^ADDRSIZE words
- DUMP_WORDS, 10, number of data words streamed after halt (1..2^ADDRSIZE)
- HALT_CODE, 5, debuger value that means halt

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- INS_ADDR  in  ADDRSIZE  instruction fetch address
- INS_MEM  out  [0:WIDTH-1]  instruction word; bit 0 is MSB
- MEM_ADDR  in  ADDRSIZE  data address
- MEM_OUT  in  [0:WIDTH-1]  CPU write data
- MEM_CTRL  in  1  data write enable (1 = write MEM_OUT to MEM_ADDR)
- MEM_IN  out  [0:WIDTH-1]  data read word returned to CPU
- debuger  in  7  CPU status code
- ld_we  in  1  preload write strobe
- ld_imem  in  1  preload target: 1 = instruction memory, 0 = data memory
- ld_addr  in  ADDRSIZE  preload address
- ld_data  in  WIDTH  preload data
- dump_valid  out  1  dump word available
- dump_ready  in  1  dump sink accepts word
- dump_addr  out  ADDRSIZE  address of current dump word
- dump_data  out  WIDTH  current dump word
- dump_done  out  1  level; all DUMP_WORDS transferred

## Operation
- FSM states: IDLE, DUMP_RD, DUMP_VLD, DONE. Reset state: IDLE.
- IDLE:
  - Instruction read: INS_MEM <= IMEM[INS_ADDR] each edge.
  - Data read: MEM_IN <= DMEM[MEM_ADDR] each edge.
  - Write: if MEM_CTRL, DMEM[MEM_ADDR] <= MEM_OUT. The read is write-through: MEM_IN takes MEM_OUT on the same edge.
  - Preload: if ld_we, the target memory is written at ld_addr. On a data-memory conflict with MEM_CTRL in the same cycle, preload wins and the CPU write is dropped, whatever the addresses.
- IDLE -> DUMP_RD when debuger == HALT_CODE is sampled at an edge. A CPU write in that same cycle is still performed. Dump counter cleared to 0.
- DUMP_RD: DMEM read address = counter. Next edge: dump_data/dump_addr loaded, dump_valid=1, go to DUMP_VLD.
- DUMP_VLD: dump_data, dump_addr and dump_valid are held stable until dump_valid && dump_ready at an edge. Then dump_valid=0, and:
  - counter == DUMP_WORDS-1 -> DONE;
  - else counter+1 -> DUMP_RD.
- DONE: dump_done=1; stays until reset.
- In every non-IDLE state:
  - MEM_CTRL and ld_we are ignored;
  - INS_MEM and MEM_IN hold their last values;
  - debuger is ignored.
- Memory contents are not reset. Reset only clears registers and the FSM.
- Counter width is ADDRSIZE; it never wraps because it stops at DUMP_WORDS-1.

## Timing
- Reset values: INS_MEM=0, MEM_IN=0, dump_valid=0, dump_addr=0, dump_data=0, dump_done=0.
- Read latency is 1 cycle on both CPU ports: the address sampled at edge N appears on the output after edge N.
- Write takes effect at the edge; a read of the same address at the next edge returns the new data.
- Halt sampled at edge E0. First dump_valid=1 after edge E1.
- With dump_ready tied high, each word takes 2 cycles (one bubble per word). dump_done rises 2*DUMP_WORDS edges after E0.
- dump_ready while dump_valid=0 has no effect.
- Reset asserted mid-dump: immediate return to IDLE with reset output values; a following halt restarts the dump at word 0.

## Structure
- Package cpu_mem_pkg holds:
  - WIDTH, ADDRSIZE and HALT_CODE defaults;
  - the FSM state encoding (2-bit localparams).
- Sub-module mem_bank: single-port synchronous RAM (WIDTH x 2^ADDRSIZE) with we, addr, wdata and registered rdata, write-through.
  - Instantiated twice: IMEM and DMEM.
  - DMEM address/write muxing (CPU, preload, dump counter) and the FSM live in cpu_mem_responder.

## Test plan
- Preload IMEM[0..3] with 0xA0000001..0xA0000004, then drive INS_ADDR 0,1,2,3 on consecutive cycles -> INS_MEM shows 0xA0000001..0xA0000004, each one cycle after its address.
- MEM_CTRL=1, MEM_ADDR=7, MEM_OUT=0x12345678 -> MEM_IN=0x12345678 the next cycle. After MEM_CTRL=0, a read of address 7 returns 0x12345678.
- ld_we=1, ld_imem=0, ld_addr=3, ld_data=0x11 in the same cycle as MEM_CTRL=1, MEM_ADDR=3, MEM_OUT=0x22 -> DMEM[3] reads back 0x11.
- DMEM[i]=i+100 for i=0..9, debuger=5, dump_ready=1 -> 10 transfers with dump_addr 0..9 and dump_data 100..109; dump_done=1 at 20 edges after halt; a later MEM_CTRL write to address 0 leaves DMEM[0]=100.
- Same setup with dump_ready low for 5 cycles on word 4 -> dump_valid, dump_addr=4 and dump_data=104 held stable throughout; no word dropped or duplicated.
- rst pulsed after the 3rd transfer -> all outputs return to reset values; a new halt restarts the dump at dump_addr=0.
